data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder.sv | 163 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Wait-state data memory responder for the core load/store bus: req/ready handshake,
// byte/half/word lane stores, sign/zero-extended loads. Optional DMEM_MISALIGN_ERR_EN.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        busReq,
  input  logic        busWe,
  input  logic [2:0]  busSize,
  input  logic [31:0] busAddr,
  input  logic [31:0] busWData,
  output logic [31:0] busRData,
  output logic        busReady,
  output logic        busErr,
  output logic [1:0]  dbg_state
);

  // Handshake: busReq is sampled only in IDLE; busReady is a single-cycle strobe
  // in RESP and busErr/busRData are valid while busReady is high.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  localparam int AW = ADDR_WIDTH + 2;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t            state, state_next;
  logic [3:0]        cnt, cnt_next;
  logic              commit;
  logic              we_q;
  logic [2:0]        size_q;
  logic [AW-1:0]     addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       mem [2**ADDR_WIDTH];

  logic              unused_addr;
  assign unused_addr = &{1'b0, busAddr[31:AW]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    commit     = 1'b0;
    case (state)
      S_IDLE: if (busReq) begin
        if (WAIT_CYCLES == 0) begin
          state_next = S_RESP;
          commit     = 1'b1;
        end else begin
          state_next = S_WAIT;
          cnt_next   = WAIT_INIT;
        end
      end
      S_WAIT: if (cnt == 4'd0) begin
        state_next = S_RESP;
        commit     = 1'b1;
      end else begin
        cnt_next = cnt - 4'd1;
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && busReq) begin
      we_q    <= busWe;
      size_q  <= busSize;
      addr_q  <= busAddr[AW-1:0];
      wdata_q <= busWData;
    end
  end

  // With zero wait states the commit edge is the capture edge, so use the live inputs.
  logic                  in_idle, a_we;
  logic [2:0]            a_size;
  logic [AW-1:0]         a_addr;
  logic [31:0]           a_wdata;
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            off;
  logic                  is_byte, is_half, acc_err;

  assign in_idle = (state == S_IDLE);
  assign a_we    = in_idle ? busWe             : we_q;
  assign a_size  = in_idle ? busSize           : size_q;
  assign a_addr  = in_idle ? busAddr[AW-1:0]   : addr_q;
  assign a_wdata = in_idle ? busWData          : wdata_q;
  assign idx     = a_addr[AW-1:2];
  assign off     = a_addr[1:0];
  assign is_byte = (a_size[1:0] == 2'b00);
  assign is_half = (a_size[1:0] == 2'b01);

`ifdef DMEM_MISALIGN_ERR_EN
  assign acc_err = (is_half && off[0]) || (!is_byte && !is_half && off != 2'b00);
`else
  assign acc_err = 1'b0;
`endif

  logic [3:0]  be;
  logic [31:0] wword, rword, rshift, load_val;
  logic        sgn;

  always_comb begin
    be       = 4'b1111;
    wword    = a_wdata;
    rword    = mem[idx];
    rshift   = rword >> {off, 3'b000};
    sgn      = ~a_size[2];
    load_val = rword;
    if (is_byte) begin
      be       = 4'b0001 << off;
      wword    = {4{a_wdata[7:0]}};
      load_val = {{24{sgn & rshift[7]}}, rshift[7:0]};
    end else if (is_half) begin
      be       = off[1] ? 4'b1100 : 4'b0011;
      wword    = {2{a_wdata[15:0]}};
      load_val = off[1] ? {{16{sgn & rword[31]}}, rword[31:16]}
                        : {{16{sgn & rword[15]}}, rword[15:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && commit && a_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wword[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= 32'd0;
    end else if (commit && (acc_err || !a_we)) begin
      rdata_q <= acc_err ? 32'd0 : load_val;
    end
  end

`ifdef DMEM_MISALIGN_ERR_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (reset)       err_q <= 1'b0;
    else if (commit) err_q <= acc_err;
  end
  assign busErr = busReady & err_q;
`else
  assign busErr = 1'b0;
`endif

  assign busReady  = (state == S_RESP);
  assign busRData  = rdata_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: lane stores, extended loads, latency,
// back-to-back requests, reset abort and misaligned handling (DMEM_MISALIGN_ERR_EN aware).
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        busReq = 1'b0, busReq0 = 1'b0;
  logic        busWe = 1'b0;
  logic [2:0]  busSize = 3'd0;
  logic [31:0] busAddr = 32'd0, busWData = 32'd0;
  logic [31:0] busRData, busRData0;
  logic        busReady, busReady0, busErr, busErr0;
  logic [1:0]  dbg_state, dbg_state0;

  int checks = 0;
  int errors = 0;

  data_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .busReq(busReq), .busWe(busWe), .busSize(busSize),
    .busAddr(busAddr), .busWData(busWData), .busRData(busRData),
    .busReady(busReady), .busErr(busErr), .dbg_state(dbg_state)
  );

  data_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .busReq(busReq0), .busWe(busWe), .busSize(busSize),
    .busAddr(busAddr), .busWData(busWData), .busRData(busRData0),
    .busReady(busReady0), .busErr(busErr0), .dbg_state(dbg_state0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts in IDLE at posedge+1; ends back in IDLE at posedge+1.
  task automatic access(input string tag, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err);
    int lat;
    lat = 0;
    busReq = 1'b1; busWe = we; busSize = size; busAddr = addr; busWData = wdata;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        busReq = 1'b0; busWe = ~we; busSize = ~size; busAddr = ~addr; busWData = ~wdata;
      end
      if (busReady) begin
        lat = c;
        break;
      end
    end
    rdata = busRData;
    err   = busErr;
    check({tag, " latency"}, 32'(lat), 32'd2);
    @(posedge clk); #1;
    check({tag, " ready_low"}, {31'd0, busReady}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  logic [7:0]  mask;
  int          pulses;

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset ready", {31'd0, busReady}, 32'd0);
    check("reset rdata", busRData, 32'd0);
    check("reset err", {31'd0, busErr}, 32'd0);
    check("reset state", {30'd0, dbg_state}, 32'd0);

    // Word store/load
    access("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er);
    access("lw10", 1'b0, 3'b010, 32'h10, 32'h0, rd, er);
    check("lw10 data", rd, 32'hDEADBEEF);
    check("lw10 err", {31'd0, er}, 32'd0);

    // Byte lane store, signed/unsigned byte loads
    access("sb13", 1'b1, 3'b000, 32'h13, 32'h00000080, rd, er);
    access("lb13", 1'b0, 3'b000, 32'h13, 32'h0, rd, er);
    check("lb13 data", rd, 32'hFFFFFF80);
    access("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, rd, er);
    check("lbu13 data", rd, 32'h00000080);
    access("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, rd, er);
    check("lw10b data", rd, 32'h80ADBEEF);

    // Half lane stores, signed/unsigned half loads
    access("sh12", 1'b1, 3'b001, 32'h12, 32'h00001234, rd, er);
    access("lw10c", 1'b0, 3'b010, 32'h10, 32'h0, rd, er);
    check("lw10c data", rd, 32'h1234BEEF);
    access("lh12", 1'b0, 3'b001, 32'h12, 32'h0, rd, er);
    check("lh12 data", rd, 32'h00001234);
    access("sh10", 1'b1, 3'b001, 32'h10, 32'h00008001, rd, er);
    access("lh10", 1'b0, 3'b001, 32'h10, 32'h0, rd, er);
    check("lh10 data", rd, 32'hFFFF8001);
    access("lhu10", 1'b0, 3'b101, 32'h10, 32'h0, rd, er);
    check("lhu10 data", rd, 32'h00008001);

    // Back-to-back loads with busReq held, one wait state
    busReq = 1'b1; busWe = 1'b0; busSize = 3'b010; busAddr = 32'h10;
    mask = 8'd0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      mask[c] = busReady;
      if (c == 5) busReq = 1'b0;
    end
    check("b2b w1 pulses", {24'd0, mask}, 32'h00000024);
    check("b2b w1 data", busRData, 32'h12348001);
    @(posedge clk); #1;

    // Same with zero wait states
    busReq0 = 1'b1;
    mask = 8'd0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      mask[c] = busReady0;
      if (c == 3) busReq0 = 1'b0;
    end
    @(posedge clk); #1;
    mask[4] = busReady0;
    check("b2b w0 pulses", {24'd0, mask}, 32'h0000000A);

    // Reset during WAIT abandons the store
    access("sw10_pre", 1'b1, 3'b010, 32'h10, 32'h11111111, rd, er);
    busReq = 1'b1; busWe = 1'b1; busSize = 3'b010; busAddr = 32'h10; busWData = 32'h22222222;
    @(posedge clk); #1;
    busReq = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("post-reset ready", {31'd0, busReady}, 32'd0);
    check("post-reset rdata", busRData, 32'd0);
    check("post-reset err", {31'd0, busErr}, 32'd0);
    check("post-reset state", {30'd0, dbg_state}, 32'd0);
    pulses = 0;
    repeat (4) begin
      @(posedge clk); #1;
      pulses += int'(busReady);
    end
    check("aborted no ready", 32'(pulses), 32'd0);
    access("lw10_rst", 1'b0, 3'b010, 32'h10, 32'h0, rd, er);
    check("lw10_rst data", rd, 32'h11111111);

    // Misaligned accesses
    access("sw10_cafe", 1'b1, 3'b010, 32'h10, 32'hCAFEF00D, rd, er);
    access("lw11", 1'b0, 3'b010, 32'h11, 32'h0, rd, er);
`ifdef DMEM_MISALIGN_ERR_EN
    check("lw11 err", {31'd0, er}, 32'd1);
    check("lw11 data", rd, 32'd0);
    access("lh11", 1'b0, 3'b001, 32'h11, 32'h0, rd, er);
    check("lh11 err", {31'd0, er}, 32'd1);
    access("sw12", 1'b1, 3'b010, 32'h12, 32'h55555555, rd, er);
    check("sw12 err", {31'd0, er}, 32'd1);
    access("lw10_mis", 1'b0, 3'b010, 32'h10, 32'h0, rd, er);
    check("lw10_mis data", rd, 32'hCAFEF00D);
    check("lw10_mis err", {31'd0, er}, 32'd0);
`else
    check("lw11 err", {31'd0, er}, 32'd0);
    check("lw11 data", rd, 32'hCAFEF00D);
    access("lh11", 1'b0, 3'b001, 32'h11, 32'h0, rd, er);
    check("lh11 data", rd, 32'hFFFFF00D);
    access("sw12", 1'b1, 3'b010, 32'h12, 32'h55555555, rd, er);
    check("sw12 err", {31'd0, er}, 32'd0);
    access("lw10_mis", 1'b0, 3'b010, 32'h10, 32'h0, rd, er);
    check("lw10_mis data", rd, 32'h55555555);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
